// File: rtl/l1_cache_pkg.sv
// Shared types and width helpers for the tag-only L1 cache model.
package l1_cache_pkg;

  // Upper bounds for line_t fields; live bits are zero-extended into them.
  localparam int L1_TAG_MAX_W = 64;
  localparam int L1_AGE_MAX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_FILL,
    ST_UPDATE,
    ST_BINV
  } l1_state_e;

  typedef enum logic {
    AGE_TOUCH,
    AGE_INVALIDATE
  } age_mode_e;

  typedef struct packed {
    logic                    valid;
    logic [L1_TAG_MAX_W-1:0] tag;
    logic [L1_AGE_MAX_W-1:0] age;
  } line_t;

  function automatic int l1_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int l1_tag_w(input int addr_w, input int idx_w, input int off_w);
    return addr_w - idx_w - off_w;
  endfunction

endpackage

// File: rtl/l1_lru_age_update.sv
// Combinational true-LRU age update for one set (age 0 = MRU).
module l1_lru_age_update
  import l1_cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic [WAYS*WAY_W-1:0] ages,
  input  logic [WAY_W-1:0]      way,
  input  age_mode_e             mode,
  output logic [WAYS*WAY_W-1:0] new_ages
);

  logic [WAY_W-1:0] old_age;
  logic [WAY_W-1:0] cur_age;

  // Touch promotes to MRU and ages the younger lines; invalidate demotes to LRU
  // and pulls the older lines one step younger, so the set stays a permutation.
  always_comb begin
    old_age  = ages[int'(way)*WAY_W +: WAY_W];
    cur_age  = '0;
    new_ages = ages;
    for (int w = 0; w < WAYS; w++) begin
      cur_age = ages[w*WAY_W +: WAY_W];
      if (WAY_W'(w) == way) begin
        new_ages[w*WAY_W +: WAY_W] = (mode == AGE_TOUCH) ? '0 : WAY_W'(WAYS - 1);
      end else if (mode == AGE_TOUCH && cur_age < old_age) begin
        new_ages[w*WAY_W +: WAY_W] = cur_age + 1'b1;
      end else if (mode == AGE_INVALIDATE && cur_age > old_age) begin
        new_ages[w*WAY_W +: WAY_W] = cur_age - 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_tag_lru_cache.sv
// Tag-only set-associative L1 with true-LRU, L2 miss handshake and back-invalidation.
// Optional prefetch-hit statistics are enabled by defining L1_PF_HIT_EN.
module l1_tag_lru_cache
  import l1_cache_pkg::*;
#(
  parameter int WAYS        = 4,
  parameter int SETS        = 512,
  parameter int BLOCK_BYTES = 16,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [l1_log2(WAYS)-1:0]       resp_way,
  output logic                           l2_req,
  output logic [ADDR_W-1:0]              l2_addr,
  input  logic                           l2_done,
  input  logic                           binv_valid,
  output logic                           binv_ready,
  input  logic [ADDR_W-1:0]              binv_addr,
  output logic [CNT_W-1:0]               hit_count,
  output logic [CNT_W-1:0]               miss_count,
  output logic [CNT_W-1:0]               binv_count
`ifdef L1_PF_HIT_EN
  ,
  input  logic                           l2_pf_hit,
  output logic [CNT_W-1:0]               pf_hit_count
`endif
);

  localparam int OFF_W  = l1_log2(BLOCK_BYTES);
  localparam int IDX_W  = l1_log2(SETS);
  localparam int WAY_W  = l1_log2(WAYS);
  localparam int TAG_W  = l1_tag_w(ADDR_W, IDX_W, OFF_W);
  localparam int LINE_W = ADDR_W - OFF_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [WAYS*WAY_W-1:0] init_ages();
    logic [WAYS*WAY_W-1:0] r;
    r = '0;
    for (int w = 0; w < WAYS; w++) r[w*WAY_W +: WAY_W] = WAY_W'(w);
    return r;
  endfunction

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS*WAY_W-1:0] age_q   [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];

  l1_state_e             state_q;
  logic [LINE_W-1:0]     line_q;
  logic [WAY_W-1:0]      hit_way_q;
  logic [WAY_W-1:0]      victim_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      cur_tag;
  line_t                 set_lines [WAYS];
  logic                  match_any;
  logic [WAY_W-1:0]      match_way;
  logic [WAY_W-1:0]      victim;
  logic [WAY_W-1:0]      upd_way;
  age_mode_e             upd_mode;
  logic [WAYS*WAY_W-1:0] new_ages;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[OFF_W-1:0], binv_addr[OFF_W-1:0]};

  assign idx     = line_q[IDX_W-1:0];
  assign cur_tag = line_q[LINE_W-1:IDX_W];

  assign req_ready  = (state_q == ST_IDLE) && !binv_valid;
  assign binv_ready = (state_q == ST_IDLE);

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      set_lines[w].valid = valid_q[idx][w];
      set_lines[w].tag   = L1_TAG_MAX_W'(tag_q[idx][w]);
      set_lines[w].age   = L1_AGE_MAX_W'(age_q[idx][w*WAY_W +: WAY_W]);
    end
  end

  always_comb begin
    match_any = 1'b0;
    match_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_lines[w].valid && set_lines[w].tag == L1_TAG_MAX_W'(cur_tag)) begin
        match_any = 1'b1;
        match_way = WAY_W'(w);
      end
    end
  end

  // An invalid way always wins over the LRU way; descending scan keeps the lowest.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_lines[w].age == L1_AGE_MAX_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_lines[w].valid) victim = WAY_W'(w);
    end
  end

  always_comb begin
    upd_way  = hit_way_q;
    upd_mode = AGE_TOUCH;
    if (state_q == ST_FILL) begin
      upd_way = victim_q;
    end else if (state_q == ST_BINV) begin
      upd_way  = match_way;
      upd_mode = AGE_INVALIDATE;
    end
  end

  l1_lru_age_update #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_age_update (
    .ages     (age_q[idx]),
    .way      (upd_way),
    .mode     (upd_mode),
    .new_ages (new_ages)
  );

  // Line state: valid and age are reset, tags are not.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= init_ages();
      end
    end else begin
      case (state_q)
        ST_UPDATE: age_q[idx] <= new_ages;
        ST_FILL: begin
          valid_q[idx][victim_q] <= 1'b1;
          age_q[idx]             <= new_ages;
        end
        ST_BINV: begin
          if (match_any) begin
            valid_q[idx][match_way] <= 1'b0;
            age_q[idx]              <= new_ages;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_FILL) tag_q[idx][victim_q] <= cur_tag;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE) begin
      line_q <= binv_valid ? binv_addr[ADDR_W-1:OFF_W] : req_addr[ADDR_W-1:OFF_W];
    end
    if (state_q == ST_LOOKUP) hit_way_q <= match_way;
    if (state_q == ST_MISS)   victim_q  <= victim;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
      l2_req       <= 1'b0;
      l2_addr      <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      binv_count   <= '0;
`ifdef L1_PF_HIT_EN
      pf_hit_count <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (binv_valid)     state_q <= ST_BINV;
          else if (req_valid) state_q <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          if (match_any) begin
            state_q    <= ST_UPDATE;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_way   <= match_way;
            hit_count  <= sat_inc(hit_count);
          end else begin
            state_q    <= ST_MISS;
            l2_req     <= 1'b1;
            l2_addr    <= {line_q, OFF_W'(0)};
            miss_count <= sat_inc(miss_count);
          end
        end
        ST_MISS: begin
          if (l2_done) begin
            state_q    <= ST_FILL;
            l2_req     <= 1'b0;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_way   <= victim;
`ifdef L1_PF_HIT_EN
            if (l2_pf_hit) pf_hit_count <= sat_inc(pf_hit_count);
`endif
          end
        end
        ST_BINV: begin
          if (match_any) binv_count <= sat_inc(binv_count);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_tag_lru_cache.sv
// Directed bench for l1_tag_lru_cache with hand-computed LRU expectations.
module tb_l1_tag_lru_cache;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        l2_req;
  logic [31:0] l2_addr;
  logic        l2_done;
  logic        binv_valid;
  logic        binv_ready;
  logic [31:0] binv_addr;
  logic [19:0] hit_count;
  logic [19:0] miss_count;
  logic [19:0] binv_count;
`ifdef L1_PF_HIT_EN
  logic        l2_pf_hit;
  logic [19:0] pf_hit_count;
`endif

  int n_vec;
  int n_err;

  l1_tag_lru_cache dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .l2_req     (l2_req),
    .l2_addr    (l2_addr),
    .l2_done    (l2_done),
    .binv_valid (binv_valid),
    .binv_ready (binv_ready),
    .binv_addr  (binv_addr),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .binv_count (binv_count)
`ifdef L1_PF_HIT_EN
    ,
    .l2_pf_hit    (l2_pf_hit),
    .pf_hit_count (pf_hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and follow it through to the return to IDLE.
  task automatic do_req(input logic [31:0] a, input logic exp_hit, input logic [1:0] exp_way,
                        input int dly);
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    step();
    if (exp_hit) begin
      check_eq("hit_resp_valid", resp_valid, 1);
      check_eq("hit_resp_hit", resp_hit, 1);
      check_eq("hit_resp_way", resp_way, exp_way);
    end else begin
      check_eq("miss_l2_req", l2_req, 1);
      check_eq("miss_l2_addr", l2_addr, a & 32'hFFFF_FFF0);
      check_eq("miss_no_resp", resp_valid, 0);
      repeat (dly) step();
      check_eq("miss_l2_req_held", l2_req, 1);
      l2_done = 1'b1;
      step();
      l2_done = 1'b0;
      check_eq("fill_resp_valid", resp_valid, 1);
      check_eq("fill_resp_hit", resp_hit, 0);
      check_eq("fill_resp_way", resp_way, exp_way);
      check_eq("fill_l2_req_low", l2_req, 0);
    end
    step();
    check_eq("resp_pulse_end", resp_valid, 0);
  endtask

  task automatic do_binv(input logic [31:0] a);
    check_eq("binv_ready_idle", binv_ready, 1);
    binv_valid = 1'b1;
    binv_addr  = a;
    #1;
    check_eq("req_ready_binv", req_ready, 0);
    step();
    binv_valid = 1'b0;
    check_eq("binv_ready_busy", binv_ready, 0);
    step();
    check_eq("binv_back_idle", binv_ready, 1);
  endtask

  localparam logic [31:0] ADDR_X = 32'h0000_1230;
  localparam logic [31:0] ADDR_A = 32'h0000_2000;
  localparam logic [31:0] ADDR_B = 32'h0000_4000;
  localparam logic [31:0] ADDR_C = 32'h0000_6000;
  localparam logic [31:0] ADDR_D = 32'h0000_8000;
  localparam logic [31:0] ADDR_E = 32'h0000_A000;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    l2_done    = 1'b0;
    binv_valid = 1'b0;
    binv_addr  = '0;
`ifdef L1_PF_HIT_EN
    l2_pf_hit  = 1'b0;
`endif
    repeat (2) step();
    reset = 1'b0;

    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_binv_ready", binv_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_l2_req", l2_req, 0);
    check_eq("rst_l2_addr", l2_addr, 0);
    check_eq("rst_counts", {hit_count, miss_count, binv_count}, 0);

    // Cold miss then hit on the same line.
    do_req(ADDR_X, 1'b0, 2'd0, 3);
    check_eq("cold_miss_count", miss_count, 1);
    do_req(ADDR_X, 1'b1, 2'd0, 0);
    check_eq("rerun_hit_count", hit_count, 1);

    // Set 0: A..D fill ways 0..3, E evicts A, then A evicts B, B evicts C.
    do_req(ADDR_A, 1'b0, 2'd0, 0);
    do_req(ADDR_B, 1'b0, 2'd1, 1);
    do_req(ADDR_C, 1'b0, 2'd2, 0);
    do_req(ADDR_D, 1'b0, 2'd3, 2);
    do_req(ADDR_E, 1'b0, 2'd0, 0);
    do_req(ADDR_A, 1'b0, 2'd1, 0);
    do_req(ADDR_B, 1'b0, 2'd2, 0);
    check_eq("lru_miss_count", miss_count, 8);

    // Invalidate resident E (way 0), refill it; invalidate absent C.
    do_binv(ADDR_E);
    check_eq("binv_count_hit", binv_count, 1);
    do_req(ADDR_E, 1'b0, 2'd0, 0);
    do_binv(ADDR_C);
    check_eq("binv_count_absent", binv_count, 1);
    do_req(ADDR_D, 1'b1, 2'd3, 0);

    // Concurrent binv and request: binv first, request accepted afterwards.
    binv_valid = 1'b1;
    binv_addr  = ADDR_D;
    req_valid  = 1'b1;
    req_addr   = ADDR_X;
    #1;
    check_eq("both_req_ready", req_ready, 0);
    step();
    binv_valid = 1'b0;
    check_eq("both_binv_busy", binv_ready, 0);
    check_eq("both_req_blocked", req_ready, 0);
    step();
    check_eq("both_binv_count", binv_count, 2);
    check_eq("both_req_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    step();
    check_eq("both_resp_valid", resp_valid, 1);
    check_eq("both_resp_hit", resp_hit, 1);
    check_eq("both_resp_way", resp_way, 0);
    step();
    check_eq("hit_count_total", hit_count, 3);

    // Reset in MISS aborts the request and clears statistics.
    req_valid = 1'b1;
    req_addr  = 32'h0000_C000;
    step();
    req_valid = 1'b0;
    step();
    check_eq("abort_l2_req_up", l2_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_l2_req_low", l2_req, 0);
    check_eq("abort_no_resp", resp_valid, 0);
    check_eq("abort_counts", {hit_count, miss_count, binv_count}, 0);
    l2_done = 1'b1;
    step();
    l2_done = 1'b0;
    check_eq("stray_done_no_resp", resp_valid, 0);
    check_eq("stray_done_no_l2_req", l2_req, 0);

    // Array was cleared: former hit line misses into way 0 again.
`ifdef L1_PF_HIT_EN
    l2_pf_hit = 1'b1;
`endif
    do_req(ADDR_X, 1'b0, 2'd0, 1);
`ifdef L1_PF_HIT_EN
    l2_pf_hit = 1'b0;
    check_eq("pf_hit_count", pf_hit_count, 1);
`endif
    check_eq("post_reset_miss_count", miss_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
